// File: rtl/alu_pipe_pkg.sv
// Shared opcode encodings, flag bit positions and multiplier FSM states for alu_pipe.
// MUL (opcode 0000) is only live when ALU_PIPE_MUL_EN is defined.
package alu_pipe_pkg;

    localparam logic [3:0] OP_MUL  = 4'b0000;
    localparam logic [3:0] OP_SETC = 4'b0001;
    localparam logic [3:0] OP_CLRC = 4'b0010;
    localparam logic [3:0] OP_NOP  = 4'b0011;
    localparam logic [3:0] OP_NOT  = 4'b0100;
    localparam logic [3:0] OP_INC  = 4'b0101;
    localparam logic [3:0] OP_DEC  = 4'b0110;
    localparam logic [3:0] OP_MOV  = 4'b0111;
    localparam logic [3:0] OP_ADD  = 4'b1000;
    localparam logic [3:0] OP_SUB  = 4'b1001;
    localparam logic [3:0] OP_AND  = 4'b1010;
    localparam logic [3:0] OP_OR   = 4'b1011;
    localparam logic [3:0] OP_SHL  = 4'b1100;
    localparam logic [3:0] OP_SHR  = 4'b1101;
    localparam logic [3:0] OP_IN   = 4'b1110;
    localparam logic [3:0] OP_OUT  = 4'b1111;

    localparam int unsigned FLG_Z = 0;
    localparam int unsigned FLG_N = 1;
    localparam int unsigned FLG_C = 2;

    typedef enum logic [1:0] {
        MulIdle = 2'd0,
        MulBusy = 2'd1,
        MulDone = 2'd2
    } mul_state_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Unsigned shift-add multiplier, one multiplier bit per cycle; used by alu_pipe
// only when ALU_PIPE_MUL_EN is defined.
module alu_mul_iter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     op1,
    input  logic [WIDTH-1:0]     op2,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int unsigned CW = $clog2(WIDTH);

    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [CW-1:0]      cnt_q;
    logic               busy_q;

    // done marks the cycle whose closing edge performs the final iteration
    assign done    = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign product = acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mcand_q  <= '0;
            acc_q    <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else if (start) begin
            mcand_q  <= {{WIDTH{1'b0}}, op1};
            acc_q    <= '0;
            mplier_q <= op2;
            cnt_q    <= '0;
            busy_q   <= 1'b1;
        end else if (busy_q) begin
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done) begin
                busy_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered execute-stage ALU with valid/ready input and persistent Z/N/C register (CCR).
// Define ALU_PIPE_MUL_EN to add the iterative MUL on opcode 0000; otherwise 0000 is a NOP.
module alu_pipe
    import alu_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    localparam int unsigned SHW  = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_operation,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic [SHW-1:0]   shamt,
    input  logic             flag_wr,
    input  logic [2:0]       flag_in,
    output logic             out_valid,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       flag
);

    logic [WIDTH-1:0] result_q;
    logic [2:0]       flag_q;
    logic             out_valid_q;

    logic             accept;
    logic             retire;
    logic             res_we;
    logic [WIDTH-1:0] res_next;
    logic [2:0]       flg_next;

    logic [WIDTH-1:0] alu_res;
    logic [2:0]       alu_flg;
    logic             alu_we;
    logic             alu_zn;
    logic [WIDTH:0]   add_ext;
    logic [WIDTH:0]   inc_ext;
    logic [WIDTH:0]   shl_ext;
    logic [WIDTH:0]   shr_ext;

    assign result    = result_q;
    assign flag      = flag_q;
    assign out_valid = out_valid_q;
    assign accept    = in_valid && in_ready;

    always_comb begin
        add_ext = {1'b0, op1} + {1'b0, op2};
        inc_ext = {1'b0, op2} + 1'b1;
        // Extra bit above/below the operand catches the last bit shifted out
        shl_ext = {1'b0, op2} << shamt;
        shr_ext = {op2, 1'b0} >> shamt;

        alu_res = result_q;
        alu_flg = flag_q;
        alu_we  = 1'b0;
        alu_zn  = 1'b0;

        case (alu_operation)
            OP_SETC: alu_flg[FLG_C] = 1'b1;
            OP_CLRC: alu_flg[FLG_C] = 1'b0;
            OP_NOT: begin
                alu_res = ~op2;
                alu_we  = 1'b1;
                alu_zn  = 1'b1;
            end
            OP_INC: begin
                alu_res        = inc_ext[WIDTH-1:0];
                alu_flg[FLG_C] = inc_ext[WIDTH];
                alu_we         = 1'b1;
                alu_zn         = 1'b1;
            end
            OP_DEC: begin
                alu_res        = op2 - 1'b1;
                alu_flg[FLG_C] = (op2 == '0);
                alu_we         = 1'b1;
                alu_zn         = 1'b1;
            end
            OP_MOV, OP_IN: begin
                alu_res = op1;
                alu_we  = 1'b1;
            end
            OP_ADD: begin
                alu_res        = add_ext[WIDTH-1:0];
                alu_flg[FLG_C] = add_ext[WIDTH];
                alu_we         = 1'b1;
                alu_zn         = 1'b1;
            end
            OP_SUB: begin
                alu_res        = op2 - op1;
                alu_flg[FLG_C] = (op2 < op1);
                alu_we         = 1'b1;
                alu_zn         = 1'b1;
            end
            OP_AND: begin
                alu_res = op1 & op2;
                alu_we  = 1'b1;
                alu_zn  = 1'b1;
            end
            OP_OR: begin
                alu_res = op1 | op2;
                alu_we  = 1'b1;
                alu_zn  = 1'b1;
            end
            OP_SHL: begin
                alu_res = shl_ext[WIDTH-1:0];
                if (shamt != '0) begin
                    alu_flg[FLG_C] = shl_ext[WIDTH];
                end
                alu_we = 1'b1;
                alu_zn = 1'b1;
            end
            OP_SHR: begin
                alu_res = shr_ext[WIDTH:1];
                if (shamt != '0) begin
                    alu_flg[FLG_C] = shr_ext[0];
                end
                alu_we = 1'b1;
                alu_zn = 1'b1;
            end
            OP_OUT: begin
                alu_res = op2;
                alu_we  = 1'b1;
            end
            default: ;
        endcase

        if (alu_zn) begin
            alu_flg[FLG_Z] = (alu_res == '0);
            alu_flg[FLG_N] = alu_res[WIDTH-1];
        end
    end

`ifdef ALU_PIPE_MUL_EN
    mul_state_t         mul_state_q;
    mul_state_t         mul_state_d;
    logic               mul_start;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;

    assign in_ready = (mul_state_q == MulIdle);

    alu_mul_iter #(
        .WIDTH (WIDTH)
    ) u_mul (
        .clk     (clk),
        .rst     (rst),
        .start   (mul_start),
        .op1     (op1),
        .op2     (op2),
        .done    (mul_done),
        .product (mul_product)
    );

    always_comb begin
        mul_state_d = mul_state_q;
        mul_start   = 1'b0;
        unique case (mul_state_q)
            MulIdle: begin
                if (accept && alu_operation == OP_MUL) begin
                    mul_start   = 1'b1;
                    mul_state_d = MulBusy;
                end
            end
            MulBusy: if (mul_done) mul_state_d = MulDone;
            MulDone: mul_state_d = MulIdle;
            default: mul_state_d = MulIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mul_state_q <= MulIdle;
        end else begin
            mul_state_q <= mul_state_d;
        end
    end

    always_comb begin
        retire   = 1'b0;
        res_we   = 1'b0;
        res_next = alu_res;
        flg_next = alu_flg;
        if (mul_state_q == MulDone) begin
            retire          = 1'b1;
            res_we          = 1'b1;
            res_next        = mul_product[WIDTH-1:0];
            flg_next[FLG_Z] = (mul_product[WIDTH-1:0] == '0);
            flg_next[FLG_N] = mul_product[WIDTH-1];
            flg_next[FLG_C] = |mul_product[2*WIDTH-1:WIDTH];
        end else if (accept && alu_operation != OP_MUL) begin
            retire = 1'b1;
            res_we = alu_we;
        end
    end
`else
    assign in_ready = 1'b1;

    always_comb begin
        retire   = accept;
        res_we   = alu_we;
        res_next = alu_res;
        flg_next = alu_flg;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            result_q    <= '0;
            flag_q      <= '0;
        end else begin
            out_valid_q <= retire;
            if (retire && res_we) begin
                result_q <= res_next;
            end
            // An explicit flag restore wins over any op retiring on the same edge
            if (flag_wr) begin
                flag_q <= flag_in;
            end else if (retire) begin
                flag_q <= flg_next;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16); MUL sequences run when ALU_PIPE_MUL_EN is defined.
module tb_alu_pipe;
    import alu_pipe_pkg::*;

    localparam int unsigned W = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [3:0]    alu_operation;
    logic [W-1:0]  op1;
    logic [W-1:0]  op2;
    logic [3:0]    shamt;
    logic          flag_wr;
    logic [2:0]    flag_in;
    logic          out_valid;
    logic [W-1:0]  result;
    logic [2:0]    flag;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [W-1:0] res;
        logic [2:0]   flg;
    } exp_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [3:0]   sh;
        logic [W-1:0] res;
        logic [2:0]   flg;
    } vec_t;

    exp_t sbq[$];
    vec_t tbl[22];

    alu_pipe #(
        .WIDTH (W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .alu_operation (alu_operation),
        .op1           (op1),
        .op2           (op2),
        .shamt         (shamt),
        .flag_wr       (flag_wr),
        .flag_in       (flag_in),
        .out_valid     (out_valid),
        .result        (result),
        .flag          (flag)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Scoreboard: every out_valid pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && out_valid === 1'b1) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_out_valid: got result %0h flag %b with nothing pending",
                         result, flag);
            end else begin
                e = sbq.pop_front();
                chk("sb_result", 32'(result), 32'(e.res));
                chk("sb_flag", 32'(flag), 32'(e.flg));
            end
        end
    end

    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [3:0] sh, input logic [W-1:0] res, input logic [2:0] flg,
                         input logic fw, input logic [2:0] fin);
        exp_t e;
        @(negedge clk);
        alu_operation = op;
        op1           = a;
        op2           = b;
        shamt         = sh;
        flag_wr       = fw;
        flag_in       = fin;
        in_valid      = 1'b1;
        e.res         = res;
        e.flg         = flg;
        sbq.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        flag_wr  = 1'b0;
    endtask

    task automatic wait_drain(input int max_cycles);
        for (int i = 0; i < max_cycles && sbq.size() != 0; i++) begin
            @(negedge clk);
        end
        @(negedge clk);
        chk("sb_drained", 32'(sbq.size()), 32'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0]  = '{OP_ADD,  16'hFFFF, 16'h0001, 4'd0, 16'h0000, 3'b101};
        tbl[1]  = '{OP_SUB,  16'h0005, 16'h0003, 4'd0, 16'hFFFE, 3'b110};
        tbl[2]  = '{OP_SETC, 16'h1111, 16'h2222, 4'd0, 16'hFFFE, 3'b110};
        tbl[3]  = '{OP_CLRC, 16'h1111, 16'h2222, 4'd0, 16'hFFFE, 3'b010};
        tbl[4]  = '{OP_SETC, 16'h0000, 16'h0000, 4'd0, 16'hFFFE, 3'b110};
        tbl[5]  = '{OP_NOT,  16'h0000, 16'hFFFF, 4'd0, 16'h0000, 3'b101};
        tbl[6]  = '{OP_INC,  16'h0000, 16'h7FFF, 4'd0, 16'h8000, 3'b010};
        tbl[7]  = '{OP_DEC,  16'h0000, 16'h0000, 4'd0, 16'hFFFF, 3'b110};
        tbl[8]  = '{OP_MOV,  16'h1234, 16'h0000, 4'd0, 16'h1234, 3'b110};
        tbl[9]  = '{OP_AND,  16'hF0F0, 16'h0FF0, 4'd0, 16'h00F0, 3'b100};
        tbl[10] = '{OP_OR,   16'h8000, 16'h0001, 4'd0, 16'h8001, 3'b110};
        tbl[11] = '{OP_CLRC, 16'h0000, 16'h0000, 4'd0, 16'h8001, 3'b010};
        tbl[12] = '{OP_SHL,  16'h0000, 16'h8001, 4'd1, 16'h0002, 3'b100};
        tbl[13] = '{OP_SHR,  16'h0000, 16'h0003, 4'd0, 16'h0003, 3'b100};
        tbl[14] = '{OP_SHR,  16'h0000, 16'h0004, 4'd2, 16'h0001, 3'b000};
        tbl[15] = '{OP_SHL,  16'h0000, 16'h00FF, 4'd8, 16'hFF00, 3'b010};
        tbl[16] = '{OP_IN,   16'hABCD, 16'h0000, 4'd0, 16'hABCD, 3'b010};
        tbl[17] = '{OP_OUT,  16'h5555, 16'h0000, 4'd0, 16'h0000, 3'b010};
        tbl[18] = '{OP_NOP,  16'hFFFF, 16'hFFFF, 4'd3, 16'h0000, 3'b010};
        tbl[19] = '{OP_ADD,  16'h8000, 16'h8000, 4'd0, 16'h0000, 3'b101};
        tbl[20] = '{OP_SUB,  16'h0003, 16'h0003, 4'd0, 16'h0000, 3'b001};
        tbl[21] = '{OP_INC,  16'h0000, 16'hFFFF, 4'd0, 16'h0000, 3'b101};

        rst           = 1'b1;
        in_valid      = 1'b0;
        alu_operation = OP_NOP;
        op1           = '0;
        op2           = '0;
        shamt         = '0;
        flag_wr       = 1'b0;
        flag_in       = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_flag", 32'(flag), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // Back-to-back single-cycle ops; flags carry from row to row
        for (int i = 0; i < 22; i++) begin
            issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, tbl[i].res, tbl[i].flg, 1'b0, 3'b000);
        end
        wait_drain(5);

        // Flag restore on the same edge an ADD would set Z and C
        issue(OP_ADD, 16'hFFFF, 16'h0001, 4'd0, 16'h0000, 3'b010, 1'b1, 3'b010);
        wait_drain(5);

        // Flag restore with no op: flag changes, no output pulse, result held
        @(negedge clk);
        flag_wr = 1'b1;
        flag_in = 3'b111;
        @(posedge clk);
        #1;
        flag_wr = 1'b0;
        chk("flag_wr_only_flag", 32'(flag), 32'b111);
        chk("flag_wr_only_result", 32'(result), 32'h0000);
        chk("flag_wr_only_no_valid", 32'(out_valid), 32'd0);

`ifndef ALU_PIPE_MUL_EN
        // Opcode 0000 without the multiplier is a NOP
        issue(4'b0000, 16'h1234, 16'h5678, 4'd0, 16'h0000, 3'b111, 1'b0, 3'b000);
        chk("nomul_in_ready", 32'(in_ready), 32'd1);
        wait_drain(5);
`endif

        // Reset wins over an op presented on the same edge
        issue(OP_MOV, 16'h5A5A, 16'h0000, 4'd0, 16'h5A5A, 3'b111, 1'b0, 3'b000);
        wait_drain(5);
        @(negedge clk);
        alu_operation = OP_ADD;
        op1           = 16'h0001;
        op2           = 16'h0001;
        in_valid      = 1'b1;
        rst           = 1'b1;
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("rst_prio_result", 32'(result), 32'd0);
        chk("rst_prio_flag", 32'(flag), 32'd0);
        chk("rst_prio_out_valid", 32'(out_valid), 32'd0);
        repeat (3) @(negedge clk);

`ifdef ALU_PIPE_MUL_EN
        begin
            exp_t e;
            int   lowcnt;
            bit   seen;
            // MUL with a second op held valid until in_ready returns
            @(negedge clk);
            alu_operation = OP_MUL;
            op1           = 16'd300;
            op2           = 16'd300;
            in_valid      = 1'b1;
            e.res = 16'h5F90;
            e.flg = 3'b100;
            sbq.push_back(e);
            @(posedge clk);
            #1;
            alu_operation = OP_ADD;
            op1           = 16'd1;
            op2           = 16'd2;
            e.res = 16'h0003;
            e.flg = 3'b000;
            sbq.push_back(e);
            lowcnt = 0;
            seen   = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                @(negedge clk);
                if (in_ready) begin
                    seen = 1'b1;
                    chk("mul_valid_with_ready", 32'(out_valid), 32'd1);
                end else begin
                    lowcnt++;
                end
            end
            chk("mul_ready_low_cycles", 32'(lowcnt), 32'd17);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            wait_drain(5);

            // Flag restore mid-MUL is visible at once, then overwritten by the MUL
            issue(OP_MUL, 16'd3, 16'd5, 4'd0, 16'h000F, 3'b000, 1'b0, 3'b000);
            repeat (2) @(negedge clk);
            flag_wr = 1'b1;
            flag_in = 3'b111;
            @(posedge clk);
            #1;
            flag_wr = 1'b0;
            chk("mul_busy_flag_wr", 32'(flag), 32'b111);
            chk("mul_busy_in_ready", 32'(in_ready), 32'd0);
            wait_drain(30);

            // Reset during BUSY aborts the MUL
            issue(OP_SETC, 16'h0000, 16'h0000, 4'd0, 16'h000F, 3'b100, 1'b0, 3'b000);
            wait_drain(5);
            @(negedge clk);
            alu_operation = OP_MUL;
            op1           = 16'd300;
            op2           = 16'd300;
            in_valid      = 1'b1;
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            repeat (4) @(negedge clk);
            rst = 1'b1;
            @(posedge clk);
            #1;
            rst = 1'b0;
            chk("mul_abort_result", 32'(result), 32'd0);
            chk("mul_abort_flag", 32'(flag), 32'd0);
            chk("mul_abort_in_ready", 32'(in_ready), 32'd1);
            chk("mul_abort_out_valid", 32'(out_valid), 32'd0);
            repeat (25) @(negedge clk);

            // Multiplier recovers after the abort
            issue(OP_MUL, 16'd3, 16'd5, 4'd0, 16'h000F, 3'b000, 1'b0, 3'b000);
            wait_drain(30);
        end
`endif

        wait_drain(5);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
Parametrised, registered successor to the execute-stage ALU. Operands are accepted under a valid/ready handshake. All results and Z/N/C flags are registered. An optional iterative multiplier adds a multi-cycle operation. It sits between the ID/EX buffer and the EX/MEM buffer, and its persistent flag register is the CCR seen by branch logic.

Parameters:
WIDTH, 16, operand/result width in bits (>=4, power of 2)
SHW, $clog2(WIDTH), shift-amount width (derived; not overridden)

Ports:
clk  in  1  clock; all state updates on rising edge
rst  in  1  synchronous reset, active-high
in_valid  in  1  operation presented this cycle
in_ready  out  1  block can accept an operation this cycle
alu_operation  in  4  opcode (encoding below)
op1  in  WIDTH  source operand 1
op2  in  WIDTH  source operand 2
shamt  in  SHW  shift amount
flag_wr  in  1  load flag register from flag_in (RTI/flag restore)
flag_in  in  3  flag restore value
out_valid  out  1  result valid; one-cycle pulse per accepted op
result  out  WIDTH  registered result; holds between ops
flag  out  3  flag register: [0]=Z, [1]=N, [2]=C

Behaviour:
- Reset: out_valid=0, result=0, flag=3'b000, multiplier idle, in_ready=1. Reset takes priority over every other event.
- An op is accepted on a rising edge with in_valid && in_ready.
- Single-cycle ops: out_valid=1 in the next cycle, with result and flag updated at that same edge.
- Opcodes:
  - 0001 SETC: C=1.
  - 0010 CLRC: C=0.
  - 0011 NOP.
  - 0100 NOT: ~op2.
  - 0101 INC: op2+1, C=carry-out.
  - 0110 DEC: op2-1, C=(op2==0).
  - 0111 MOV: op1.
  - 1000 ADD: op1+op2, C=carry-out.
  - 1001 SUB: op2-op1, C=(op2<op1) unsigned borrow.
  - 1010 AND.
  - 1011 OR.
  - 1100 SHL: op2<<shamt, C=op2[WIDTH-shamt].
  - 1101 SHR: op2>>shamt logical, C=op2[shamt-1].
  - 1110 IN: op1.
  - 1111 OUT: op2.
  - 0000 MUL: only when the optional feature is compiled in.
- Z/N update from the new result for NOT, INC, DEC, ADD, SUB, AND, OR, SHL, SHR and MUL. Z=(result==0), N=result[WIDTH-1].
- MOV, IN, OUT: result written; flags unchanged.
- SETC, CLRC, NOP: result holds its previous value; Z/N unchanged; out_valid still pulses.
- SHL/SHR with shamt==0: result=op2; C unchanged.
- Any flag bit not named for an op holds its value.
- flag_wr=1: flag<=flag_in at that edge. This overrides any flag update from an op retiring on the same edge. result and out_valid are unaffected.
- in_ready=1 except while a MUL is in progress.
- No back-pressure on the output: the consumer must sample result on out_valid.

Optional Feature:
Macro ALU_PIPE_MUL_EN.
- Defined, opcode 0000 = MUL: unsigned op1*op2 via a shift-add iteration, one bit per cycle.
  - State machine IDLE -> BUSY (WIDTH cycles) -> DONE (1 cycle) -> IDLE.
  - in_ready=0 in BUSY and DONE.
  - out_valid pulses at the edge leaving DONE, i.e. WIDTH+1 cycles after acceptance.
  - result = low WIDTH bits of the product. C=1 iff the high WIDTH bits are nonzero. Z/N from result.
  - rst during BUSY/DONE aborts the MUL: no out_valid, state returns to IDLE, outputs take reset values.
  - flag_wr during BUSY is applied immediately. The MUL's later flag update then overwrites Z/N/C.
- Not defined: opcode 0000 behaves as NOP and in_ready is constant 1.

Decomposition:
- Package alu_pipe_pkg holds:
  - 4-bit opcode localparams (OP_MUL..OP_OUT, values above).
  - Flag index constants FLG_Z=0, FLG_N=1, FLG_C=2.
  - The MUL state enum (IDLE/BUSY/DONE).
- Sub-module alu_mul_iter (WIDTH parameter; start/op1/op2 in; done/product[2*WIDTH] out) holds the iterative multiplier.
  - It is instantiated only under ALU_PIPE_MUL_EN.
  - The top level handles opcode decode, the flag register and the handshake.

Test Plan:
1. WIDTH=16: ADD op1=16'hFFFF, op2=16'h0001 -> next cycle: out_valid=1, result=16'h0000, flag=3'b101 (C=1, Z=1).
2. SUB op1=5, op2=3 -> result=16'hFFFE, flag=3'b110 (C=1, N=1). SETC then CLRC back-to-back -> C=1 then C=0; result unchanged.
3. SHL op2=16'h8001, shamt=1 -> result=16'h0002, C=1. SHR op2=16'h0003, shamt=0 -> result=16'h0003, C unchanged.
4. flag_wr=1 with flag_in=3'b010 on the same edge an ADD retires with Z=1 -> flag=3'b010.
5. With ALU_PIPE_MUL_EN: MUL op1=300, op2=300 -> in_ready=0 for 17 cycles; out_valid at cycle 17; result=16'h5F90, C=1. A second op held valid meanwhile is accepted only once in_ready returns to 1.
6. rst asserted at cycle 5 of a MUL -> no out_valid; next cycle result=0, flag=0, in_ready=1.
